// File: rtl/rst_seq_pkg.sv
// Shared types for the Wishbone-domain reset sequencer.
package rst_seq_pkg;

   localparam int unsigned ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_RESET      = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_WAIT_CALIB = 3'd2,
      ST_DLY_PERIPH = 3'd3,
      ST_DLY_CPU    = 3'd4,
      ST_RUN        = 3'd5,
      ST_SOFT       = 3'd6
   } state_t;

endpackage

// File: rtl/rst_seq_sync_ff.sv
// Multi-stage flop synchroniser for a single asynchronous status bit.
module sync_ff #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], d};
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: releases memory, peripheral and CPU resets in order once
// the PLL is locked and DDR2 calibration has finished (or timed out).
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STAGE_DELAY   = 16,
   parameter int unsigned CALIB_TIMEOUT = 65535,
   parameter int unsigned SOFT_HOLD     = 16,
   parameter int unsigned CNT_W         = 16
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            lock_i,
   input  logic            calib_done_i,
   input  logic            soft_rst_req_i,
   output logic            mem_rst_o,
   output logic            periph_rst_o,
   output logic            cpu_rst_o,
   output logic            seq_done_o,
   output logic            calib_timeout_o,
   output logic [ST_W-1:0] state_o
);

   localparam logic [CNT_W-1:0] DLY_LAST   = CNT_W'(STAGE_DELAY - 1);
   localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_HOLD - 1);

   logic lk;
   logic cd;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cnt_clr;
   logic             mem_q, mem_d;
   logic             periph_q, periph_d;
   logic             cpu_q, cpu_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .d   (lock_i),
      .q   (lk)
   );

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_calib (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .d   (calib_done_i),
      .q   (cd)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= ST_RESET;
         cnt_q     <= '0;
         mem_q     <= 1'b1;
         periph_q  <= 1'b1;
         cpu_q     <= 1'b1;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_q     <= mem_d;
         periph_q  <= periph_d;
         cpu_q     <= cpu_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   // Lock loss overrides every other transition, including a soft request.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cnt_clr   = 1'b0;
      mem_d     = mem_q;
      periph_d  = periph_q;
      cpu_d     = cpu_q;
      done_d    = done_q;
      timeout_d = timeout_q;

      if (state_q != ST_RESET && state_q != ST_WAIT_LOCK && !lk) begin
         state_d  = ST_WAIT_LOCK;
         mem_d    = 1'b1;
         periph_d = 1'b1;
         cpu_d    = 1'b1;
         done_d   = 1'b0;
      end else begin
         case (state_q)
            ST_RESET: state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
               if (!lk) begin
                  cnt_clr = 1'b1;
               end else if (cnt_q == DLY_LAST) begin
                  state_d = ST_WAIT_CALIB;
                  mem_d   = 1'b0;
               end
            end
            ST_WAIT_CALIB: begin
               if (cd) begin
                  state_d = ST_DLY_PERIPH;
               end else if (cnt_q == CALIB_LAST) begin
                  state_d   = ST_DLY_PERIPH;
                  timeout_d = 1'b1;
               end
            end
            ST_DLY_PERIPH: begin
               if (cnt_q == DLY_LAST) begin
                  state_d  = ST_DLY_CPU;
                  periph_d = 1'b0;
               end
            end
            ST_DLY_CPU: begin
               if (cnt_q == DLY_LAST) begin
                  state_d = ST_RUN;
                  cpu_d   = 1'b0;
                  done_d  = 1'b1;
               end
            end
            ST_RUN: begin
               if (soft_rst_req_i) begin
                  state_d  = ST_SOFT;
                  periph_d = 1'b1;
                  cpu_d    = 1'b1;
                  done_d   = 1'b0;
               end
            end
            ST_SOFT: begin
               if (cnt_q == SOFT_LAST) state_d = ST_DLY_PERIPH;
            end
            default: state_d = ST_RESET;
         endcase
      end

      // Counter restarts on every state entry and saturates instead of wrapping.
      if (cnt_clr || state_d != state_q) cnt_d = '0;
      else if (cnt_q != '1)              cnt_d = cnt_q + CNT_W'(1);
   end

   assign mem_rst_o       = mem_q;
   assign periph_rst_o    = periph_q;
   assign cpu_rst_o       = cpu_q;
   assign seq_done_o      = done_q;
   assign calib_timeout_o = timeout_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed self-checking bench for rst_seq with short delays.
module tb_rst_seq;

   logic       wb_clk_i       = 1'b0;
   logic       wb_rst_i       = 1'b1;
   logic       lock_i         = 1'b0;
   logic       calib_done_i   = 1'b0;
   logic       soft_rst_req_i = 1'b0;
   logic       mem_rst_o, periph_rst_o, cpu_rst_o, seq_done_o, calib_timeout_o;
   logic [2:0] state_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mem_fall, periph_fall, cpu_fall, done_rise, to_rise;
   int mem_rise, periph_rise, cpu_rise;

   always #5 wb_clk_i = ~wb_clk_i;

   rst_seq #(
      .SYNC_STAGES   (2),
      .STAGE_DELAY   (4),
      .CALIB_TIMEOUT (20),
      .SOFT_HOLD     (3),
      .CNT_W         (16)
   ) dut (
      .wb_clk_i        (wb_clk_i),
      .wb_rst_i        (wb_rst_i),
      .lock_i          (lock_i),
      .calib_done_i    (calib_done_i),
      .soft_rst_req_i  (soft_rst_req_i),
      .mem_rst_o       (mem_rst_o),
      .periph_rst_o    (periph_rst_o),
      .cpu_rst_o       (cpu_rst_o),
      .seq_done_o      (seq_done_o),
      .calib_timeout_o (calib_timeout_o),
      .state_o         (state_o)
   );

   // Ordering invariant sampled on every falling edge.
   always @(negedge wb_clk_i) begin
      total++;
      if ((mem_rst_o === 1'b1 && periph_rst_o !== 1'b1) ||
          (periph_rst_o === 1'b1 && cpu_rst_o !== 1'b1)) begin
         bad++;
         $display("FAIL order_invariant t=%0t mem=%b periph=%b cpu=%b required mem<=periph<=cpu",
                  $time, mem_rst_o, periph_rst_o, cpu_rst_o);
      end
   end

   // One clock, then record which outputs toggled at that edge.
   task automatic tick();
      logic pm, pp, pc, pd, pt;
      pm = mem_rst_o; pp = periph_rst_o; pc = cpu_rst_o; pd = seq_done_o; pt = calib_timeout_o;
      @(posedge wb_clk_i);
      #1;
      cyc++;
      if (pm === 1'b1 && mem_rst_o === 1'b0)    mem_fall    = cyc;
      if (pp === 1'b1 && periph_rst_o === 1'b0) periph_fall = cyc;
      if (pc === 1'b1 && cpu_rst_o === 1'b0)    cpu_fall    = cyc;
      if (pm === 1'b0 && mem_rst_o === 1'b1)    mem_rise    = cyc;
      if (pp === 1'b0 && periph_rst_o === 1'b1) periph_rise = cyc;
      if (pc === 1'b0 && cpu_rst_o === 1'b1)    cpu_rise    = cyc;
      if (pd === 1'b0 && seq_done_o === 1'b1)   done_rise   = cyc;
      if (pt === 1'b0 && calib_timeout_o === 1'b1) to_rise  = cyc;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic do_release();
      wb_rst_i       = 1'b1;
      soft_rst_req_i = 1'b0;
      @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;
      cyc = 0;
      mem_fall = -1; periph_fall = -1; cpu_fall = -1; done_rise = -1; to_rise = -1;
      mem_rise = -1; periph_rise = -1; cpu_rise = -1;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      total++; if (mem_rst_o !== 1'b1) begin bad++; $display("FAIL rst_mem got=%b exp=1", mem_rst_o); end
      total++; if (periph_rst_o !== 1'b1) begin bad++; $display("FAIL rst_periph got=%b exp=1", periph_rst_o); end
      total++; if (cpu_rst_o !== 1'b1) begin bad++; $display("FAIL rst_cpu got=%b exp=1", cpu_rst_o); end
      total++; if (seq_done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", seq_done_o); end
      total++; if (calib_timeout_o !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", calib_timeout_o); end
      total++; if (state_o !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_o); end
   endtask

   task automatic test_nominal();
      lock_i = 1'b0; calib_done_i = 1'b0;
      do_release();
      tick();
      total++; if (state_o !== 3'd1) begin bad++; $display("FAIL nom_first_edge state got=%0d exp=1", state_o); end
      run_to(10); lock_i = 1'b1;
      run_to(30); calib_done_i = 1'b1;
      run_to(45);
      total++; if (mem_fall != 16) begin bad++; $display("FAIL nom_mem_fall got=%0d exp=16", mem_fall); end
      total++; if (periph_fall != 37) begin bad++; $display("FAIL nom_periph_fall got=%0d exp=37", periph_fall); end
      total++; if (cpu_fall != 41) begin bad++; $display("FAIL nom_cpu_fall got=%0d exp=41", cpu_fall); end
      total++; if (done_rise != 41) begin bad++; $display("FAIL nom_done_rise got=%0d exp=41", done_rise); end
      total++; if (state_o !== 3'd5) begin bad++; $display("FAIL nom_state got=%0d exp=5", state_o); end
      total++; if (calib_timeout_o !== 1'b0) begin bad++; $display("FAIL nom_timeout got=%b exp=0", calib_timeout_o); end
   endtask

   task automatic test_soft();
      int s;
      soft_rst_req_i = 1'b1;
      tick();
      soft_rst_req_i = 1'b0;
      s = cyc;
      total++; if (periph_rst_o !== 1'b1 || cpu_rst_o !== 1'b1) begin bad++; $display("FAIL soft_assert periph=%b cpu=%b exp=1,1", periph_rst_o, cpu_rst_o); end
      total++; if (mem_rst_o !== 1'b0) begin bad++; $display("FAIL soft_mem got=%b exp=0", mem_rst_o); end
      total++; if (state_o !== 3'd6 || seq_done_o !== 1'b0) begin bad++; $display("FAIL soft_state state=%0d done=%b exp=6,0", state_o, seq_done_o); end
      tick();
      soft_rst_req_i = 1'b1;
      tick();
      soft_rst_req_i = 1'b0;
      total++; if (state_o !== 3'd6) begin bad++; $display("FAIL soft_second_req state got=%0d exp=6", state_o); end
      run_to(s + 12);
      total++; if (periph_fall != s + 7) begin bad++; $display("FAIL soft_periph_fall got=%0d exp=%0d", periph_fall, s + 7); end
      total++; if (cpu_fall != s + 11) begin bad++; $display("FAIL soft_cpu_fall got=%0d exp=%0d", cpu_fall, s + 11); end
      total++; if (done_rise != s + 11 || state_o !== 3'd5) begin bad++; $display("FAIL soft_done done_rise=%0d state=%0d exp=%0d,5", done_rise, state_o, s + 11); end
   endtask

   task automatic test_lock_loss();
      int n;
      int m;
      n = cyc;
      lock_i = 1'b0;
      tick();
      tick();
      total++; if (state_o !== 3'd5) begin bad++; $display("FAIL loss_sync_delay state got=%0d exp=5", state_o); end
      soft_rst_req_i = 1'b1;
      tick();
      soft_rst_req_i = 1'b0;
      total++; if (state_o !== 3'd1) begin bad++; $display("FAIL loss_state got=%0d exp=1", state_o); end
      total++; if (mem_rise != n + 3 || periph_rise != n + 3 || cpu_rise != n + 3) begin
         bad++; $display("FAIL loss_rise mem=%0d periph=%0d cpu=%0d exp=%0d", mem_rise, periph_rise, cpu_rise, n + 3);
      end
      total++; if (seq_done_o !== 1'b0) begin bad++; $display("FAIL loss_done got=%b exp=0", seq_done_o); end
      run_to(n + 8);
      total++; if (state_o !== 3'd1 || mem_rst_o !== 1'b1) begin bad++; $display("FAIL loss_hold state=%0d mem=%b exp=1,1", state_o, mem_rst_o); end
      m = cyc;
      lock_i = 1'b1;
      run_to(m + 16);
      total++; if (mem_fall != m + 6) begin bad++; $display("FAIL relock_mem_fall got=%0d exp=%0d", mem_fall, m + 6); end
      total++; if (periph_fall != m + 11) begin bad++; $display("FAIL relock_periph_fall got=%0d exp=%0d", periph_fall, m + 11); end
      total++; if (cpu_fall != m + 15 || state_o !== 3'd5) begin bad++; $display("FAIL relock_cpu_fall got=%0d state=%0d exp=%0d,5", cpu_fall, state_o, m + 15); end
   endtask

   task automatic test_lock_glitch();
      lock_i = 1'b0; calib_done_i = 1'b0;
      do_release();
      run_to(5);  lock_i = 1'b1;
      run_to(8);  lock_i = 1'b0;
      run_to(20);
      total++; if (state_o !== 3'd1 || mem_rst_o !== 1'b1 || mem_fall != -1) begin
         bad++; $display("FAIL glitch_hold state=%0d mem=%b mem_fall=%0d exp=1,1,-1", state_o, mem_rst_o, mem_fall);
      end
      lock_i = 1'b1;
      run_to(30);
      total++; if (mem_fall != 26) begin bad++; $display("FAIL glitch_mem_fall got=%0d exp=26", mem_fall); end
      total++; if (state_o !== 3'd2) begin bad++; $display("FAIL glitch_state got=%0d exp=2", state_o); end
   endtask

   task automatic test_timeout();
      run_to(45);
      total++; if (calib_timeout_o !== 1'b0 || state_o !== 3'd2) begin bad++; $display("FAIL to_early timeout=%b state=%0d exp=0,2", calib_timeout_o, state_o); end
      run_to(60);
      total++; if (to_rise != 46) begin bad++; $display("FAIL to_rise got=%0d exp=46", to_rise); end
      total++; if (periph_fall != 50 || cpu_fall != 54) begin bad++; $display("FAIL to_seq periph=%0d cpu=%0d exp=50,54", periph_fall, cpu_fall); end
      total++; if (state_o !== 3'd5 || seq_done_o !== 1'b1) begin bad++; $display("FAIL to_run state=%0d done=%b exp=5,1", state_o, seq_done_o); end
      lock_i = 1'b0;
      run_to(66);
      total++; if (state_o !== 3'd1 || mem_rst_o !== 1'b1) begin bad++; $display("FAIL to_loss state=%0d mem=%b exp=1,1", state_o, mem_rst_o); end
      total++; if (calib_timeout_o !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", calib_timeout_o); end
      lock_i = 1'b1;
   endtask

   task automatic test_async_reset();
      run_to(98);
      total++; if (state_o !== 3'd4) begin bad++; $display("FAIL async_pre state got=%0d exp=4", state_o); end
      total++; if (mem_rst_o !== 1'b0 || periph_rst_o !== 1'b0 || cpu_rst_o !== 1'b1) begin
         bad++; $display("FAIL async_pre_rst mem=%b periph=%b cpu=%b exp=0,0,1", mem_rst_o, periph_rst_o, cpu_rst_o);
      end
      #2;
      wb_rst_i = 1'b1;
      #1;
      total++; if (mem_rst_o !== 1'b1 || periph_rst_o !== 1'b1 || cpu_rst_o !== 1'b1) begin
         bad++; $display("FAIL async_rst mem=%b periph=%b cpu=%b exp=1,1,1", mem_rst_o, periph_rst_o, cpu_rst_o);
      end
      total++; if (seq_done_o !== 1'b0 || calib_timeout_o !== 1'b0) begin
         bad++; $display("FAIL async_flags done=%b timeout=%b exp=0,0", seq_done_o, calib_timeout_o);
      end
      total++; if (state_o !== 3'd0) begin bad++; $display("FAIL async_state got=%0d exp=0", state_o); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_soft();
      test_lock_loss();
      test_lock_glitch();
      test_timeout();
      test_async_reset();
      repeat (2) @(posedge wb_clk_i);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
